mem_port_arbiter: RTL

- Shares one single-ported unified memory between the CPU's instruction-fetch port and its data port.
- Grants one access at a time, sequences the memory timing and returns read data with a one-cycle ready pulse.
- Drives a STALL output; the CPU uses ~STALL as its PC enable, so an instruction completes only when both of its accesses have finished.
- Sits between the cpu top and the memory model, replacing separate IMEM/DMEM.

---
 rtl/cpu_mem_pkg.sv | 26 ++
 rtl/sync_mem_model.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-port arbiter: FSM state encoding,
// access owner encoding and the legal memory latency range.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W       = 4;

  // Value loaded into the latency counter when leaving ISSUE for WAIT.
  function automatic logic [CNT_W-1:0] lat_init_cnt(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/sync_mem_model.sv
// Small single-ported memory with a configurable read latency and a
// back-door load port used to preload contents. Word-indexed by ADDR[.:2];
// upper address bits alias.
module sync_mem_model #(
  parameter int MEM_LAT    = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic              CLK,
  input  logic              CS,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] RDATA,
  input  logic              LD_EN,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [DATA_W-1:0] LD_DATA
);

  logic [DATA_W-1:0]     mem_q [0:(2**DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] idx;
  logic [DEPTH_LOG2-1:0] ld_idx;
  logic                  unused_bits;

  assign idx    = ADDR[DEPTH_LOG2+1:2];
  assign ld_idx = LD_ADDR[DEPTH_LOG2+1:2];
  assign unused_bits = ^{ADDR[ADDR_W-1:DEPTH_LOG2+2], ADDR[1:0],
                         LD_ADDR[ADDR_W-1:DEPTH_LOG2+2], LD_ADDR[1:0]};

  // Storage write: back-door load wins over a functional write.
  always_ff @(posedge CLK) begin
    if (LD_EN) begin
      mem_q[ld_idx] <= LD_DATA;
    end else if (CS && WE) begin
      mem_q[idx] <= WDATA;
    end
  end

  // Read path: data is valid MEM_LAT-1 cycles after the select cycle.
  generate
    if (MEM_LAT == 1) begin : g_comb_rd
      assign RDATA = mem_q[idx];
    end else begin : g_pipe_rd
      logic [DATA_W-1:0] pipe_q [0:MEM_LAT-2];
      // Delay line for read data; the address is held by the requester.
      always_ff @(posedge CLK) begin
        pipe_q[0] <= mem_q[idx];
        for (int i = 1; i < MEM_LAT - 1; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign RDATA = pipe_q[MEM_LAT-2];
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the instruction-fetch port and the
// data port. One access at a time, data port has fixed priority.
//
// Handshake: a requester raises REQ (level) with its address/data stable and
// keeps it high until its RDY pulses for exactly one cycle; RDATA is valid in
// that cycle and holds until the same port's next RDY. Request inputs are
// only sampled in IDLE; REQ high in the cycle after RDY is a new request.
// STALL is high whenever some port has an outstanding request not yet RDY.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_RDY,
  output logic [DATA_W-1:0] IF_RDATA,
  input  logic              DM_REQ,
  input  logic              DM_WE,
  input  logic [ADDR_W-1:0] DM_ADDR,
  input  logic [DATA_W-1:0] DM_WDATA,
  output logic              DM_RDY,
  output logic [DATA_W-1:0] DM_RDATA,
  output logic              MEM_CS,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              STALL,
  output logic [1:0]        dbg_state_o
);

  localparam logic [CNT_W-1:0] CNT_INIT = lat_init_cnt(MEM_LAT);

  state_e            state_q;
  owner_e            own_q;
  logic              we_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mem_cs_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_rdy_q;
  logic              dm_rdy_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              done;

  // Last ISSUE/WAIT cycle of an access: read data is valid on MEM_RDATA now.
  always_comb begin
    done = 1'b0;
    if (state_q == ST_ISSUE && MEM_LAT == 1) begin
      done = 1'b1;
    end else if (state_q == ST_WAIT && cnt_q == CNT_W'(1)) begin
      done = 1'b1;
    end
  end

  // Arbitration FSM with registered memory strobes, capture and RDY pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      own_q       <= OWN_IF;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdy_q    <= 1'b0;
      dm_rdy_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      mem_cs_q <= 1'b0;
      mem_we_q <= 1'b0;
      if_rdy_q <= 1'b0;
      dm_rdy_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The pending data access belongs to the current instruction.
          if (DM_REQ) begin
            own_q       <= OWN_DM;
            we_q        <= DM_WE;
            mem_addr_q  <= DM_ADDR;
            mem_wdata_q <= DM_WDATA;
            mem_cs_q    <= 1'b1;
            mem_we_q    <= DM_WE;
            state_q     <= ST_ISSUE;
          end else if (IF_REQ) begin
            own_q      <= OWN_IF;
            we_q       <= 1'b0;
            mem_addr_q <= IF_ADDR;
            mem_cs_q   <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (MEM_LAT == 1) begin
            state_q <= ST_RESP;
          end else begin
            cnt_q   <= CNT_INIT;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      if (done) begin
        if (own_q == OWN_DM) begin
          dm_rdy_q <= 1'b1;
          if (!we_q) begin
            dm_rdata_q <= MEM_RDATA;
          end
        end else begin
          if_rdy_q   <= 1'b1;
          if_rdata_q <= MEM_RDATA;
        end
      end
    end
  end

  assign IF_RDY      = if_rdy_q;
  assign IF_RDATA    = if_rdata_q;
  assign DM_RDY      = dm_rdy_q;
  assign DM_RDATA    = dm_rdata_q;
  assign MEM_CS      = mem_cs_q;
  assign MEM_WE      = mem_we_q;
  assign MEM_ADDR    = mem_addr_q;
  assign MEM_WDATA   = mem_wdata_q;
  assign STALL       = (IF_REQ & ~if_rdy_q) | (DM_REQ & ~dm_rdy_q);
  assign dbg_state_o = state_q;

endmodule
